// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled UART receiver (start-bit validation, framing and
// overrun detection) feeding a first-word-fall-through receive FIFO.
// Optional feature macro: UART_RX_PARITY_EN adds one even-parity bit per frame
// and drives parity_err; without it parity_err is tied low.
module uart_rx_fifo #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 4800,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          sysclk,
    input  logic                          reset,
    input  logic                          UART_RX,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          overrun_err,
    output logic                          parity_err
);
    localparam int DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = $clog2(DIV + 1);
    localparam int TW    = $clog2(OVERSAMPLE);
    localparam int BW    = $clog2(DATA_BITS);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    // Line synchroniser and edge history
    logic rx_s1_q, rx_s2_q, rx_prev_q;
    // Oversample tick divider
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;
    // Receive FSM
    state_t                 state_q;
    logic [TW-1:0]          tick_cnt_q;
    logic [BW-1:0]          bit_cnt_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   frame_err_q;
    logic                   start_det, samp_half, samp_full, push;
    // FIFO
    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   overrun_q, overrun_d;
    logic                   pop, push_ok;

    // Two-flop synchroniser; idle-high reset so no false start after reset
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= UART_RX;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    assign start_det = (state_q == S_IDLE) && rx_prev_q && !rx_s2_q;
    assign samp_half = tick && (tick_cnt_q == TW'(OVERSAMPLE / 2 - 1));
    assign samp_full = tick && (tick_cnt_q == TW'(OVERSAMPLE - 1));

    // Free-running divider, realigned to the start-bit falling edge
    always_comb begin
        div_d = div_q + DIV_W'(1);
        tick  = 1'b0;
        if (start_det) begin
            div_d = '0;
        end else if (div_q == DIV_W'(DIV - 1)) begin
            div_d = '0;
            tick  = 1'b1;
        end
    end

    // Divider register
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) div_q <= '0;
        else        div_q <= div_d;
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad_q, parity_err_q;
    assign push       = (state_q == S_STOP) && samp_full && rx_s2_q && !par_bad_q;
    assign parity_err = parity_err_q;
`else
    assign push       = (state_q == S_STOP) && samp_full && rx_s2_q;
    assign parity_err = 1'b0;
`endif

    // Receive FSM: validate start at mid-bit, then sample every OVERSAMPLE ticks
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            if (tick) tick_cnt_q <= tick_cnt_q + TW'(1);
            case (state_q)
                S_IDLE: if (start_det) begin
                    tick_cnt_q <= '0;
                    state_q    <= S_START;
                end
                S_START: if (samp_half) begin
                    tick_cnt_q <= '0;
                    bit_cnt_q  <= '0;
                    // Line back high at mid-start is a glitch, not a frame
                    state_q    <= rx_s2_q ? S_IDLE : S_DATA;
                end
                S_DATA: if (samp_full) begin
                    tick_cnt_q <= '0;
                    shift_q    <= {rx_s2_q, shift_q[DATA_BITS-1:1]};
                    bit_cnt_q  <= bit_cnt_q + BW'(1);
                    if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_q <= S_PARITY;
`else
                        state_q <= S_STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: if (samp_full) begin
                    tick_cnt_q   <= '0;
                    par_bad_q    <= (^shift_q) ^ rx_s2_q;
                    parity_err_q <= (^shift_q) ^ rx_s2_q;
                    state_q      <= S_STOP;
                end
`endif
                S_STOP: if (samp_full) begin
                    tick_cnt_q <= '0;
                    if (rx_s2_q) begin
                        state_q <= S_IDLE;
                    end else begin
                        frame_err_q <= 1'b1;
                        state_q     <= S_BREAK;
                    end
                end
                S_BREAK: if (rx_s2_q) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // FIFO control: a pop frees the slot a same-cycle push needs when full
    always_comb begin
        pop       = rd_en && (count_q != '0);
        push_ok   = push && ((count_q != CW'(FIFO_DEPTH)) || pop);
        overrun_d = push && !push_ok;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
        if (push_ok && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push_ok) count_d = count_q - CW'(1);
    end

    // FIFO pointers, occupancy and overrun pulse
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // FIFO storage; cleared on reset so the head reads 0
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset)       mem_q <= '{default: '0};
        else if (push_ok) mem_q[wr_ptr_q] <= shift_q;
    end

    assign rd_data     = mem_q[rd_ptr_q];
    assign count       = count_q;
    assign empty       = (count_q == '0);
    assign full        = (count_q == CW'(FIFO_DEPTH));
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed vector table, hand-written corner sequences
// (glitch, reset mid-frame) and a randomized phase checked against a queue model.
module tb_uart_rx_fifo;
    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 6250;
    localparam int OS     = 16;
    localparam int DB     = 8;
    localparam int DEPTH  = 4;
    localparam int BIT    = CLK_HZ / BAUD;   // 160 clocks per bit, DIV = 10
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN  = 1'b1;
`else
    localparam bit PAR_EN  = 1'b0;
`endif
    // Clocks from the line falling to the edge that stores the byte: 2 sync
    // flops + edge detect, then the stop sample on tick 8 + 16*(DB+PAR+1),
    // one tick every 10 clocks.
    localparam int POP_OFF = 3 + 10 * (8 + 16 * (DB + (PAR_EN ? 1 : 0) + 1)) - 1;

    logic                   sysclk, reset, UART_RX, rd_en;
    logic [DB-1:0]          rd_data;
    logic                   empty, full, frame_err, overrun_err, parity_err;
    logic [$clog2(DEPTH):0] count;

    uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS),
                   .DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) dut (
        .sysclk(sysclk), .reset(reset), .UART_RX(UART_RX), .rd_en(rd_en),
        .rd_data(rd_data), .empty(empty), .full(full), .count(count),
        .frame_err(frame_err), .overrun_err(overrun_err), .parity_err(parity_err)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    int checks = 0, errors = 0;
    int ferr_cnt = 0, ovr_cnt = 0, perr_cnt = 0;

    // Count error pulse cycles
    always @(negedge sysclk) begin
        if (frame_err)   ferr_cnt <= ferr_cnt + 1;
        if (overrun_err) ovr_cnt  <= ovr_cnt + 1;
        if (parity_err)  perr_cnt <= perr_cnt + 1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit         send;
        logic [7:0] data;
        bit         stop_ok;
        bit         par_bad;
        int         idle_before;
        int         pop_at;
        int         pops;
        int         exp_count;
        logic [7:0] exp_head;
        int         exp_ferr;
        int         exp_ovr;
        int         exp_perr;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mk(bit s, logic [7:0] d, bit so, bit pb, int idl, int pa,
                                int np, int ec, logic [7:0] eh, int ef, int eo, int ep);
        vec_t v;
        v.send = s; v.data = d; v.stop_ok = so; v.par_bad = pb; v.idle_before = idl;
        v.pop_at = pa; v.pops = np; v.exp_count = ec; v.exp_head = eh;
        v.exp_ferr = ef; v.exp_ovr = eo; v.exp_perr = ep;
        return v;
    endfunction

    task automatic chk(input string tag, input string what, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s %s: got %0d expected %0d", tag, what, act, exp);
        end
    endtask

    task automatic drive_line(input logic v, input int nbits);
        UART_RX = v;
        repeat (nbits * BIT) @(posedge sysclk);
        #1;
    endtask

    // Bad-stop frames keep the line low for three bit times from the stop slot
    task automatic send_frame(input logic [7:0] data, input bit stop_ok, input bit par_bad);
        drive_line(1'b0, 1);
        for (int i = 0; i < DB; i++) drive_line(data[i], 1);
        if (PAR_EN) drive_line((^data) ^ par_bad, 1);
        if (stop_ok) drive_line(1'b1, 1);
        else         drive_line(1'b0, 3);
        UART_RX = 1'b1;
    endtask

    task automatic apply_frame(input logic [7:0] data, input bit stop_ok, input bit par_bad,
                               input int pop_at);
        fork
            send_frame(data, stop_ok, par_bad);
            begin
                if (pop_at >= 0) begin
                    repeat (pop_at) @(posedge sysclk);
                    #1 rd_en = 1'b1;
                    @(posedge sysclk);
                    #1 rd_en = 1'b0;
                end
            end
        join
    endtask

    task automatic do_pop();
        rd_en = 1'b1;
        @(posedge sysclk);
        #1 rd_en = 1'b0;
    endtask

    task automatic check_state(input string tag, input int ec, input logic [7:0] eh,
                               input int ef, input int eo, input int ep);
        @(negedge sysclk);
        chk(tag, "count", int'(count), ec);
        chk(tag, "empty", int'(empty), int'(ec == 0));
        chk(tag, "full", int'(full), int'(ec == DEPTH));
        if (ec > 0) chk(tag, "rd_data", int'(rd_data), int'(eh));
        chk(tag, "frame_err pulses", ferr_cnt, ef);
        chk(tag, "overrun_err pulses", ovr_cnt, eo);
        chk(tag, "parity_err pulses", perr_cnt, ep);
        @(posedge sysclk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk(tag, "rd_data", int'(rd_data), 0);
        chk(tag, "empty", int'(empty), 1);
        chk(tag, "full", int'(full), 0);
        chk(tag, "count", int'(count), 0);
        chk(tag, "err pulses", int'({frame_err, overrun_err, parity_err}), 0);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] b54, d;
        int tot_f, tot_o, tot_p;
        bit good, pb;
        int np;

        reset = 1'b1; UART_RX = 1'b1; rd_en = 1'b0;
        #2 reset = 1'b0;
        #6 check_reset_vals("reset");
        #4 reset = 1'b1;
        @(posedge sysclk);
        #1;

        // Directed vectors; expectations are cumulative pulse counts
        vecs.push_back(mk(1, 8'h54, 1, 0, 1, -1, 0, 1, 8'h54, 0, 0, 0));
        vecs.push_back(mk(1, 8'h0C, 1, 0, 2, -1, 1, 1, 8'h0C, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, -1, 1, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(1, 8'h11, 1, 0, 1, -1, 0, 1, 8'h11, 0, 0, 0));
        vecs.push_back(mk(1, 8'h22, 1, 0, 1, -1, 0, 2, 8'h11, 0, 0, 0));
        vecs.push_back(mk(1, 8'h33, 1, 0, 1, -1, 0, 3, 8'h11, 0, 0, 0));
        vecs.push_back(mk(1, 8'h44, 1, 0, 1, -1, 0, 4, 8'h11, 0, 0, 0));
        vecs.push_back(mk(1, 8'h55, 1, 0, 1, -1, 0, 4, 8'h11, 0, 1, 0));
        // Pop lands on the push edge while full: accepted, no overrun
        vecs.push_back(mk(1, 8'h66, 1, 0, 1, POP_OFF, 0, 4, 8'h22, 0, 1, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, -1, 1, 3, 8'h33, 0, 1, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, -1, 1, 2, 8'h44, 0, 1, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, -1, 1, 1, 8'h66, 0, 1, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, -1, 1, 0, 8'h00, 0, 1, 0));
        vecs.push_back(mk(1, 8'h3C, 0, 0, 1, -1, 0, 0, 8'h00, 1, 1, 0));
        vecs.push_back(mk(1, 8'hA5, 1, 0, 1, -1, 0, 1, 8'hA5, 1, 1, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, -1, 1, 0, 8'h00, 1, 1, 0));
        if (PAR_EN) begin
            vecs.push_back(mk(1, 8'h54, 1, 1, 1, -1, 0, 0, 8'h00, 1, 1, 1));
            vecs.push_back(mk(1, 8'h54, 1, 0, 1, -1, 0, 1, 8'h54, 1, 1, 1));
            vecs.push_back(mk(0, 8'h00, 1, 0, 0, -1, 1, 0, 8'h00, 1, 1, 1));
        end

        foreach (vecs[k]) begin
            vec_t v;
            v = vecs[k];
            if (v.idle_before > 0) drive_line(1'b1, v.idle_before);
            if (v.send) apply_frame(v.data, v.stop_ok, v.par_bad, v.pop_at);
            for (int p = 0; p < v.pops; p++) do_pop();
            check_state($sformatf("vec%0d", k), v.exp_count, v.exp_head,
                        v.exp_ferr, v.exp_ovr, v.exp_perr);
        end
        tot_f = vecs[vecs.size()-1].exp_ferr;
        tot_o = vecs[vecs.size()-1].exp_ovr;
        tot_p = vecs[vecs.size()-1].exp_perr;

        // Short low glitch on the idle line: no byte, no error
        drive_line(1'b1, 1);
        UART_RX = 1'b0;
        repeat (38) @(posedge sysclk);
        #1 UART_RX = 1'b1;
        drive_line(1'b1, 2);
        check_state("glitch", 0, 8'h00, tot_f, tot_o, tot_p);
        send_frame(8'h3A, 1, 0);
        check_state("after_glitch", 1, 8'h3A, tot_f, tot_o, tot_p);
        do_pop();

        // Reset in the middle of the data bits of 0x54 with a byte queued
        drive_line(1'b1, 1);
        send_frame(8'h77, 1, 0);
        check_state("pre_reset", 1, 8'h77, tot_f, tot_o, tot_p);
        drive_line(1'b1, 1);
        b54 = 8'h54;
        drive_line(1'b0, 1);
        for (int i = 0; i < 4; i++) drive_line(b54[i], 1);
        repeat (BIT / 2) @(posedge sysclk);
        #1 reset = 1'b0;
        #2 check_reset_vals("mid_frame_reset");
        UART_RX = 1'b1;
        repeat (3) @(posedge sysclk);
        #1 reset = 1'b1;
        drive_line(1'b1, 2);
        send_frame(8'h54, 1, 0);
        check_state("post_reset", 1, 8'h54, tot_f, tot_o, tot_p);
        do_pop();
        check_state("drained", 0, 8'h00, tot_f, tot_o, tot_p);

        // Randomized frames against the queue model
        for (int it = 0; it < 12; it++) begin
            d    = 8'($urandom);
            good = ($urandom_range(0, 7) != 0);
            pb   = PAR_EN && ($urandom_range(0, 5) == 0);
            drive_line(1'b1, $urandom_range(1, 2));
            send_frame(d, good, pb);
            if (!good) tot_f++;
            if (pb) tot_p++;
            if (good && !pb) begin
                if (q.size() == DEPTH) tot_o++;
                else q.push_back(d);
            end
            np = $urandom_range(0, 2);
            for (int p = 0; p < np; p++) begin
                do_pop();
                if (q.size() > 0) void'(q.pop_front());
            end
            check_state($sformatf("rand%0d", it), q.size(),
                        (q.size() > 0) ? q[0] : 8'h00, tot_f, tot_o, tot_p);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with oversampled start-bit validation, framing/overrun detection and a first-word-fall-through receive FIFO. It replaces the fixed 8N1 receive path in `top`. It sits between the board `UART_RX` pin and the CPU's memory-mapped UART peripheral registers, which drain bytes with `rd_en`.

## Interface
- `CLK_HZ`, 100_000_000, `sysclk` frequency in Hz.
- `BAUD`, 4800, line rate; bit period 208333 ns at default.
- `OVERSAMPLE`, 16, sample ticks per bit; even, ≥ 4.
- `DATA_BITS`, 8, payload bits per frame, 5–9, LSB first.
- `FIFO_DEPTH`, 4, receive FIFO entries; power of two, ≥ 2.
- `sysclk`  in  1  system clock, single clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `UART_RX`  in  1  serial line, idle high, asynchronous to `sysclk`.
- `rd_en`  in  1  pop the FIFO head; ignored when `empty`.
- `rd_data`  out  DATA_BITS  FIFO head, valid while `empty`=0.
- `empty`  out  1  FIFO holds no bytes.
- `full`  out  1  FIFO holds FIFO_DEPTH bytes.
- `count`  out  $clog2(FIFO_DEPTH)+1  bytes held.
- `frame_err`  out  1  one-cycle pulse, stop bit sampled 0.
- `overrun_err`  out  1  one-cycle pulse, byte dropped because FIFO full.
- `parity_err`  out  1  one-cycle pulse, parity mismatch (only under macro, else tied 0).

## Operation
- `UART_RX` passes through a 2-FF synchroniser. Both flops reset to 1. The FSM sees only the synchronised value.
- Tick generator: `DIV = CLK_HZ/(BAUD*OVERSAMPLE)`, integer truncation (1302 at defaults). `tick` pulses one cycle every DIV clocks. The divider free-runs and restarts at 0 on the start-bit falling edge.
- FSM states and transitions:
  - IDLE: go to START on synchronised 1→0.
  - START: wait OVERSAMPLE/2 ticks. If the line is still 0, go to DATA. If 1, treat as a glitch and return to IDLE with no error.
  - DATA: sample once every OVERSAMPLE ticks, DATA_BITS times, shifting into bit position LSB-first.
  - PARITY: macro only, one sample.
  - STOP: one sample after OVERSAMPLE ticks.
    - Stop = 1: push to the FIFO and return to IDLE.
    - Stop = 0: pulse `frame_err`, discard the byte, go to BREAK.
  - BREAK: return to IDLE when the synchronised line reads 1.
- FIFO:
  - Write and read pointers are $clog2(FIFO_DEPTH) bits, wrapping modulo FIFO_DEPTH. `count` is tracked separately.
  - `full` = (count==FIFO_DEPTH); `empty` = (count==0).
  - Push while full: byte dropped, `overrun_err` pulses, contents unchanged.
  - Push and pop in the same cycle while full: the pop retires first and the push is accepted; no overrun, `count` unchanged.
  - Push and pop in the same cycle at any other non-empty count: `count` unchanged.
  - Pop while empty: no effect.
- Reset mid-frame: FSM returns to IDLE, the partial byte is lost, FIFO is cleared, all pointers go to 0.

## Timing
- Output reset values: `rd_data`=0, `empty`=1, `full`=0, `count`=0, all error pulses 0.
- Line-edge to FSM latency: 2 `sysclk` (synchroniser).
- `empty` deasserts and `rd_data` is valid 1 cycle after the `tick` on which the stop bit is sampled.
- `rd_data` is first-word-fall-through. After `rd_en` at the rising edge, the next head is shown in the following cycle; `count` updates in that same cycle.
- Error pulses assert in the cycle after the offending sample tick, for exactly one cycle.
- Tolerates ±2 % baud mismatch at OVERSAMPLE=16.

## Configuration
- `UART_RX_PARITY_EN`
  - Defined: each frame carries one parity bit after the data bits, even parity. On mismatch, `parity_err` pulses and the byte is discarded, not pushed. The stop bit is still checked.
  - Undefined: no PARITY state, and `parity_err` is constant 0.

## Test plan
- Reset pulse low 10 ns, then frame 0x54 (start, bits 0,0,1,0,1,0,1,0, stop) at 208333 ns/bit → `rd_data`=0x54, `count`=1, no error pulses.
- Follow with 0x0C after a 416666 ns idle gap. Pop once → `rd_data`=0x0C, `count`=1; pop again → `empty`=1.
- Drive 5 frames with no pops, FIFO_DEPTH=4 → `full`=1, one `overrun_err` pulse, head still holds the first byte.
- Frame with stop bit 0, line held low 3 bit times → one `frame_err` pulse, `count` unchanged. The next valid frame 0xA5 is received correctly.
- 50 µs low glitch on idle line → no byte pushed, no error, FSM back in IDLE.
- Assert `reset` low mid-data of 0x54 → outputs at reset values. The next full frame is received correctly.
- With `UART_RX_PARITY_EN`: 0x54 with parity bit 0 (wrong) → `parity_err` pulse, nothing pushed.
